// File: rtl/pkt_buf_rd_resp.sv
// Read-side responder of one packet-buffer bank: streams SRAM cells as beats, then releases the cell run.
// Optional statistics counters are built when RD_RESP_STAT_EN is defined.
module pkt_buf_rd_resp #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 64,
  parameter int PORT_W = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCmdVld,
  output logic              oCmdRdy,
  input  logic [ADDR_W-1:0] iCmdAddr,
  input  logic [LEN_W-1:0]  iCmdLen,
  input  logic [PORT_W-1:0] iCmdDst,
  input  logic              iCmdDrop,
  output logic              oMemRdEn,
  output logic [ADDR_W-1:0] oMemRdAddr,
  input  logic [DATA_W-1:0] iMemRdData,
  output logic              oDataVld,
  input  logic              iDataRdy,
  output logic [DATA_W-1:0] oData,
  output logic              oLast,
  output logic [PORT_W-1:0] oDataDst,
`ifdef RD_RESP_STAT_EN
  output logic [31:0]       oStatPkt,
  output logic [31:0]       oStatDrop,
  output logic [31:0]       oStatBeat,
`endif
  output logic              oFreeVld,
  input  logic              iFreeRdy,
  output logic [ADDR_W-1:0] oFreeAddr,
  output logic [LEN_W-1:0]  oFreeLen
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FREE = 2'd2} rdStateT;

  rdStateT           stateReg, stateNext;
  logic              rdyEnReg;
  logic [ADDR_W-1:0] addrReg;
  logic [LEN_W-1:0]  lenReg;
  logic [LEN_W-1:0]  beatReg;
  logic [PORT_W-1:0] dstReg;

  logic              inflightReg;
  logic              inflightLastReg;
  logic [PORT_W-1:0] inflightDstReg;

  logic [DATA_W-1:0] fifoData [2];
  logic              fifoLast [2];
  logic [PORT_W-1:0] fifoDst  [2];
  logic              wrPtrReg, rdPtrReg;
  logic [1:0]        fifoCntReg;

  logic              fifoEmpty, pop, fifoPush, fifoPop;
  logic              canIssue, accept, issue;
  logic [2:0]        occ;

  assign fifoEmpty = (fifoCntReg == 2'd0);

  // The word returning from SRAM is presented directly when nothing older is queued,
  // which gives first-beat-valid two cycles after command accept.
  always_comb begin
    oData    = '0;
    oLast    = 1'b0;
    oDataDst = '0;
    if (!fifoEmpty) begin
      oData    = fifoData[rdPtrReg];
      oLast    = fifoLast[rdPtrReg];
      oDataDst = fifoDst[rdPtrReg];
    end else if (inflightReg) begin
      oData    = iMemRdData;
      oLast    = inflightLastReg;
      oDataDst = inflightDstReg;
    end
  end

  assign oDataVld = !fifoEmpty || inflightReg;
  assign pop      = oDataVld && iDataRdy;
  assign fifoPop  = pop && !fifoEmpty;
  assign fifoPush = inflightReg && !(fifoEmpty && pop);

  // Credit check: queued + in-flight words, less the one leaving now, must leave room for one more.
  assign occ      = {1'b0, fifoCntReg} + {2'b00, inflightReg};
  assign canIssue = occ < (3'd2 + {2'b00, pop});

  always_comb begin
    stateNext = stateReg;
    oCmdRdy   = 1'b0;
    oFreeVld  = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    unique case (stateReg)
      IDLE: begin
        oCmdRdy = rdyEnReg;
        if (iCmdVld && rdyEnReg) begin
          accept    = 1'b1;
          stateNext = iCmdDrop ? FREE : READ;
        end
      end
      READ: begin
        if (canIssue) begin
          issue = 1'b1;
          if (beatReg == lenReg) stateNext = FREE;
        end
      end
      FREE: begin
        oFreeVld = 1'b1;
        if (iFreeRdy) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign oMemRdEn   = issue;
  assign oMemRdAddr = issue ? (addrReg + ADDR_W'(beatReg)) : '0;
  assign oFreeAddr  = oFreeVld ? addrReg : '0;
  assign oFreeLen   = oFreeVld ? lenReg : '0;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg        <= IDLE;
      rdyEnReg        <= 1'b0;
      addrReg         <= '0;
      lenReg          <= '0;
      beatReg         <= '0;
      dstReg          <= '0;
      inflightReg     <= 1'b0;
      inflightLastReg <= 1'b0;
      inflightDstReg  <= '0;
      wrPtrReg        <= 1'b0;
      rdPtrReg        <= 1'b0;
      fifoCntReg      <= 2'd0;
    end else begin
      // Ready is held off for the first cycle out of reset so every output starts at 0.
      rdyEnReg <= 1'b1;
      stateReg <= stateNext;
      if (accept) begin
        addrReg <= iCmdAddr;
        lenReg  <= iCmdLen;
        dstReg  <= iCmdDst;
        beatReg <= '0;
      end else if (issue) begin
        beatReg <= beatReg + 1'b1;
      end
      inflightReg <= issue;
      if (issue) begin
        inflightLastReg <= (beatReg == lenReg);
        inflightDstReg  <= dstReg;
      end
      if (fifoPush) wrPtrReg <= ~wrPtrReg;
      if (fifoPop)  rdPtrReg <= ~rdPtrReg;
      fifoCntReg <= fifoCntReg + {1'b0, fifoPush} - {1'b0, fifoPop};
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge iClk) begin
    if (fifoPush) begin
      fifoData[wrPtrReg] <= iMemRdData;
      fifoLast[wrPtrReg] <= inflightLastReg;
      fifoDst[wrPtrReg]  <= inflightDstReg;
    end
  end

`ifdef RD_RESP_STAT_EN
  logic [2:0] statInc;
  assign statInc = {pop, accept && iCmdDrop, pop && oLast};

  for (genvar gi = 0; gi < 3; gi++) begin : gStat
    logic [31:0] cntReg;
    always_ff @(posedge iClk) begin
      if (iRst) begin
        cntReg <= '0;
      end else if (statInc[gi] && (cntReg != 32'hFFFF_FFFF)) begin
        cntReg <= cntReg + 32'd1;
      end
    end
  end

  assign oStatPkt  = gStat[0].cntReg;
  assign oStatDrop = gStat[1].cntReg;
  assign oStatBeat = gStat[2].cntReg;
`endif

endmodule
